// File: rtl/mips_wb_pkg.sv
// Shared writeback types: request record, FSM states and the r0-discard helper.
package mips_wb_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_req_t;

   typedef enum logic {
      WB_NORMAL = 1'b0,
      WB_FORCE  = 1'b1
   } wb_state_e;

   // Writes to r0 never consume a port slot or a FIFO entry.
   function automatic logic wb_live(input wb_req_t r);
      return r.valid && (r.addr != '0);
   endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback-side bundle: pipe/LL requests in, register-file write ports and stall out.
interface regfile_wb_arbiter_if;
   import mips_wb_pkg::*;

   logic                  p1_valid;
   logic [REG_ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0]     p1_data;
   logic                  p2_valid;
   logic [REG_ADDR_W-1:0] p2_addr;
   logic [DATA_W-1:0]     p2_data;
   logic                  ll_valid;
   logic                  ll_ready;
   logic [REG_ADDR_W-1:0] ll_addr;
   logic [DATA_W-1:0]     ll_data;
   logic                  wb_stall;
   logic                  reg_w_en_1;
   logic [REG_ADDR_W-1:0] reg_w_addr_1;
   logic [DATA_W-1:0]     reg_w_data_1;
   logic                  reg_w_en_2;
   logic [REG_ADDR_W-1:0] reg_w_addr_2;
   logic [DATA_W-1:0]     reg_w_data_2;

   modport master (
      output p1_valid, p1_addr, p1_data,
      output p2_valid, p2_addr, p2_data,
      output ll_valid, ll_addr, ll_data,
      input  ll_ready, wb_stall,
      input  reg_w_en_1, reg_w_addr_1, reg_w_data_1,
      input  reg_w_en_2, reg_w_addr_2, reg_w_data_2
   );

   modport slave (
      input  p1_valid, p1_addr, p1_data,
      input  p2_valid, p2_addr, p2_data,
      input  ll_valid, ll_addr, ll_data,
      output ll_ready, wb_stall,
      output reg_w_en_1, reg_w_addr_1, reg_w_data_1,
      output reg_w_en_2, reg_w_addr_2, reg_w_data_2
   );
endinterface

// File: rtl/wb_ll_fifo.sv
// LL result queue with up to two pops per cycle (head0 oldest, head1 next); pops see state before push.
// Latency: push visible at head next cycle; push while full is ignored, caller gates on full.
module wb_ll_fifo
   import mips_wb_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  wb_req_t          push_req,
   input  logic             pop0,
   input  logic             pop1,
   output wb_req_t          head0,
   output wb_req_t          head1,
   output logic             full,
   output logic             empty,
   output logic [PTR_W-1:0] count
);
   localparam int IDX_W = PTR_W - 1;

   wb_req_t          mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_1;
   logic [PTR_W-1:0] pop_n;
   logic             do_push;

   assign do_push  = push && !full;
   assign rd_ptr_1 = rd_ptr + PTR_W'(1);
   assign pop_n    = pop1 ? PTR_W'(2) : (pop0 ? PTR_W'(1) : '0);

   // Extra pointer bit separates the full and empty cases when indices match.
   assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign count = wr_ptr - rd_ptr;
   assign head0 = mem[rd_ptr[IDX_W-1:0]];
   assign head1 = mem[rd_ptr_1[IDX_W-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[IDX_W-1:0]] <= push_req;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(do_push);
         rd_ptr <= rd_ptr + pop_n;
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares two register-file write ports between pipe 1/2 and queued LL results; 1-cycle registered outputs.
// LL backpressure via ll_ready=!full; starvation forces wb_stall. WB_PERF_CNT_EN adds perf counters.
module regfile_wb_arbiter
   import mips_wb_pkg::*;
#(
   parameter int LL_DEPTH     = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   regfile_wb_arbiter_if.slave   bus
`ifdef WB_PERF_CNT_EN
   ,
   output logic [31:0]           perf_stall_cyc,
   output logic [31:0]           perf_ll_drained
`endif
);
   localparam int CNT_W    = $clog2(LL_DEPTH) + 1;
   localparam int STARVE_W = $clog2(STARVE_LIMIT) + 1;

   wb_req_t          p1_req;
   wb_req_t          p2_req;
   wb_req_t          ll_req;
   wb_req_t          head0;
   wb_req_t          head1;
   wb_req_t          port1_nxt;
   wb_req_t          port2_nxt;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             push;
   logic             pop0;
   logic             pop1;
   logic             p1_take;
   logic             p2_take;
   logic [1:0]       n_free;
   logic [1:0]       n_avail;
   logic [1:0]       n_drain;
   logic             stall_nxt;

   wb_state_e             state_q;
   wb_state_e             state_nxt;
   logic [STARVE_W-1:0]   starve_q;
   logic [STARVE_W-1:0]   starve_nxt;

   always_comb begin
      p1_req = '{valid: bus.p1_valid, addr: bus.p1_addr, data: bus.p1_data};
      p2_req = '{valid: bus.p2_valid, addr: bus.p2_addr, data: bus.p2_data};
      ll_req = '{valid: 1'b1,         addr: bus.ll_addr, data: bus.ll_data};
   end

   assign push        = bus.ll_valid && !fifo_full && (bus.ll_addr != '0);
   assign bus.ll_ready = !fifo_full;

   wb_ll_fifo #(
      .DEPTH (LL_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_req (ll_req),
      .pop0     (pop0),
      .pop1     (pop1),
      .head0    (head0),
      .head1    (head1),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // Pipes own their ports; LL entries fill whatever is left, oldest into the lowest free port.
   always_comb begin
      p2_take   = wb_live(p2_req);
      p1_take   = wb_live(p1_req) && !(p2_take && (p2_req.addr == p1_req.addr));
      n_free    = 2'(!p1_take) + 2'(!p2_take);
      n_avail   = (fifo_count >= CNT_W'(2)) ? 2'd2 : 2'(fifo_count);
      n_drain   = (n_free < n_avail) ? n_free : n_avail;
      pop0      = (n_drain != 2'd0);
      pop1      = (n_drain == 2'd2);
      port1_nxt = '0;
      port2_nxt = '0;
      if (p1_take) begin
         port1_nxt = p1_req;
      end else if (pop0) begin
         port1_nxt = head0;
      end
      if (p2_take) begin
         port2_nxt = p2_req;
      end else if (pop1) begin
         port2_nxt = head1;
      end else if (pop0 && p1_take) begin
         port2_nxt = head0;
      end
   end

   always_comb begin
      state_nxt  = state_q;
      starve_nxt = starve_q;
      case (state_q)
         WB_NORMAL: begin
            if (!fifo_empty && !pop0) begin
               if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) begin
                  state_nxt  = WB_FORCE;
                  starve_nxt = '0;
               end else begin
                  starve_nxt = starve_q + STARVE_W'(1);
               end
            end else begin
               starve_nxt = '0;
            end
         end
         WB_FORCE: begin
            if (fifo_empty) begin
               state_nxt  = WB_NORMAL;
               starve_nxt = '0;
            end
         end
         default: begin
            state_nxt  = WB_NORMAL;
            starve_nxt = '0;
         end
      endcase
      stall_nxt = (state_nxt == WB_FORCE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= WB_NORMAL;
         starve_q         <= '0;
         bus.wb_stall     <= 1'b0;
         bus.reg_w_en_1   <= 1'b0;
         bus.reg_w_addr_1 <= '0;
         bus.reg_w_data_1 <= '0;
         bus.reg_w_en_2   <= 1'b0;
         bus.reg_w_addr_2 <= '0;
         bus.reg_w_data_2 <= '0;
      end else begin
         state_q          <= state_nxt;
         starve_q         <= starve_nxt;
         bus.wb_stall     <= stall_nxt;
         bus.reg_w_en_1   <= port1_nxt.valid;
         bus.reg_w_addr_1 <= port1_nxt.addr;
         bus.reg_w_data_1 <= port1_nxt.data;
         bus.reg_w_en_2   <= port2_nxt.valid;
         bus.reg_w_addr_2 <= port2_nxt.addr;
         bus.reg_w_data_2 <= port2_nxt.data;
      end
   end

`ifdef WB_PERF_CNT_EN
   logic [32:0] drained_sum;

   assign drained_sum = {1'b0, perf_ll_drained} + 33'(n_drain);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall_cyc  <= '0;
         perf_ll_drained <= '0;
      end else begin
         if (bus.wb_stall && (perf_stall_cyc != '1)) begin
            perf_stall_cyc <= perf_stall_cyc + 32'd1;
         end
         perf_ll_drained <= drained_sum[32] ? '1 : drained_sum[31:0];
      end
   end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-based reference model, per-cycle compare, directed and random traffic.
module tb_regfile_wb_arbiter;
   import mips_wb_pkg::*;

   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   regfile_wb_arbiter_if bus_if ();

   regfile_wb_arbiter #(
      .LL_DEPTH     (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   int          m_cnt;
   bit          m_force;
   logic        e_en [2];
   logic [4:0]  e_a  [2];
   logic [31:0] e_d  [2];
   logic [31:0] rf   [32];
   logic [31:0] mrf  [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit queued(input logic [4:0] a);
      foreach (mq[i]) if (mq[i].a == a) return 1'b1;
      return 1'b0;
   endfunction

   // Reference: pipes claim their own ports, queued LL results fill free ports oldest-first.
   task automatic model_step();
      int          n0;
      int          drained;
      bit          take [2];
      logic [4:0]  pa   [2];
      logic [31:0] pd   [2];
      ent_t        e;
      pa[0]   = bus_if.p1_addr;
      pd[0]   = bus_if.p1_data;
      pa[1]   = bus_if.p2_addr;
      pd[1]   = bus_if.p2_data;
      take[1] = bus_if.p2_valid && (pa[1] != 0);
      take[0] = bus_if.p1_valid && (pa[0] != 0) && !(take[1] && pa[1] == pa[0]);
      n0 = mq.size();
      for (int p = 0; p < 2; p++) begin
         e_en[p] = 1'b0;
         e_a[p]  = '0;
         e_d[p]  = '0;
         if (take[p]) begin
            e_en[p] = 1'b1;
            e_a[p]  = pa[p];
            e_d[p]  = pd[p];
         end else if (mq.size() > 0) begin
            e       = mq.pop_front();
            e_en[p] = 1'b1;
            e_a[p]  = e.a;
            e_d[p]  = e.d;
         end
      end
      drained = n0 - mq.size();
      if (bus_if.ll_valid && n0 < DEPTH && bus_if.ll_addr != 0) begin
         e.a = bus_if.ll_addr;
         e.d = bus_if.ll_data;
         mq.push_back(e);
      end
      if (!m_force) begin
         if (n0 > 0 && drained == 0) begin
            if (m_cnt == LIMIT - 1) begin
               m_force = 1'b1;
               m_cnt   = 0;
            end else begin
               m_cnt++;
            end
         end else begin
            m_cnt = 0;
         end
      end else if (n0 == 0) begin
         m_force = 1'b0;
         m_cnt   = 0;
      end
      for (int p = 0; p < 2; p++) if (e_en[p]) mrf[e_a[p]] = e_d[p];
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         mq.delete();
         m_cnt   = 0;
         m_force = 1'b0;
         for (int p = 0; p < 2; p++) begin
            e_en[p] = 1'b0;
            e_a[p]  = '0;
            e_d[p]  = '0;
         end
         chk("rst_en1", 32'(bus_if.reg_w_en_1), 32'd0);
         chk("rst_en2", 32'(bus_if.reg_w_en_2), 32'd0);
         chk("rst_stall", 32'(bus_if.wb_stall), 32'd0);
         chk("rst_ready", 32'(bus_if.ll_ready), 32'd1);
      end else begin
         if (bus_if.reg_w_en_1) rf[bus_if.reg_w_addr_1] = bus_if.reg_w_data_1;
         if (bus_if.reg_w_en_2) rf[bus_if.reg_w_addr_2] = bus_if.reg_w_data_2;
         chk("en1", 32'(bus_if.reg_w_en_1), 32'(e_en[0]));
         chk("addr1", 32'(bus_if.reg_w_addr_1), 32'(e_a[0]));
         chk("data1", bus_if.reg_w_data_1, e_d[0]);
         chk("en2", 32'(bus_if.reg_w_en_2), 32'(e_en[1]));
         chk("addr2", 32'(bus_if.reg_w_addr_2), 32'(e_a[1]));
         chk("data2", bus_if.reg_w_data_2, e_d[1]);
         chk("stall", 32'(bus_if.wb_stall), 32'(m_force));
         chk("ll_ready", 32'(bus_if.ll_ready), 32'(mq.size() < DEPTH));
         model_step();
      end
   end

   task automatic drive(input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic v2, input logic [4:0] a2, input logic [31:0] d2,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
      bus_if.p1_valid = v1;
      bus_if.p1_addr  = a1;
      bus_if.p1_data  = d1;
      bus_if.p2_valid = v2;
      bus_if.p2_addr  = a2;
      bus_if.p2_data  = d2;
      bus_if.ll_valid = lv;
      bus_if.ll_addr  = la;
      bus_if.ll_data  = ld;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pipe destinations never alias a pending LL destination (upstream scoreboard guarantee).
   function automatic logic [4:0] pick(input logic [4:0] avoid1, input logic [4:0] avoid2);
      logic [4:0] a;
      for (int t = 0; t < 64; t++) begin
         a = 5'($urandom_range(31));
         if (a == 0 || (!queued(a) && a != avoid1 && a != avoid2)) return a;
      end
      return 5'd0;
   endfunction

   task automatic rand_cycle(input int busy);
      logic       v1, v2, lv;
      logic [4:0] a1, a2, la;
      v1 = !m_force && ($urandom_range(99) < busy);
      v2 = !m_force && ($urandom_range(99) < busy);
      a1 = pick(5'd0, 5'd0);
      a2 = ($urandom_range(7) == 0) ? a1 : pick(5'd0, 5'd0);
      la = ($urandom_range(9) == 0) ? 5'd0 : pick(v1 ? a1 : 5'd0, v2 ? a2 : 5'd0);
      lv = 1'($urandom_range(1));
      drive(v1, a1, $urandom, v2, a2, $urandom, lv, la, $urandom);
   endtask

   initial begin
      for (int r = 0; r < 32; r++) begin
         rf[r]  = '0;
         mrf[r] = '0;
      end
      idle();
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      repeat (400) begin
         rand_cycle(85);
         tick();
      end

      // Asynchronous reset in the middle of traffic
      @(negedge clk);
      #3 reset = 1'b0;
      @(posedge clk);
      #1;
      chk("t1_en1", 32'(bus_if.reg_w_en_1), 32'd0);
      chk("t1_en2", 32'(bus_if.reg_w_en_2), 32'd0);
      chk("t1_ready", 32'(bus_if.ll_ready), 32'd1);
      chk("t1_stall", 32'(bus_if.wb_stall), 32'd0);
      chk("t1_count", 32'(dut.u_fifo.count), 32'd0);
      idle();
      tick();
      reset = 1'b1;
      tick();

      // Same destination on both pipes: younger pipe 2 wins
      drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 1'b0, 5'd0, 32'd0);
      tick();
      chk("t2_en1", 32'(bus_if.reg_w_en_1), 32'd0);
      chk("t2_en2", 32'(bus_if.reg_w_en_2), 32'd1);
      chk("t2_addr2", 32'(bus_if.reg_w_addr_2), 32'd3);
      chk("t2_data2", bus_if.reg_w_data_2, 32'hB);
      idle();
      tick();
      chk("t2_rf3", rf[3], 32'hB);

      // Two queued LL entries drain together, oldest on port 1
      drive(1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h101, 1'b1, 5'd5, 32'd1);
      tick();
      drive(1'b1, 5'd12, 32'h102, 1'b1, 5'd13, 32'h103, 1'b1, 5'd6, 32'd2);
      tick();
      idle();
      tick();
      chk("t3_a1", 32'(bus_if.reg_w_addr_1), 32'd5);
      chk("t3_d1", bus_if.reg_w_data_1, 32'd1);
      chk("t3_a2", 32'(bus_if.reg_w_addr_2), 32'd6);
      chk("t3_d2", bus_if.reg_w_data_2, 32'd2);
      chk("t3_count", 32'(dut.u_fifo.count), 32'd0);
      tick();

      // Only pipe 1 busy: LL entry takes port 2
      drive(1'b1, 5'd14, 32'h200, 1'b1, 5'd15, 32'h201, 1'b1, 5'd7, 32'd9);
      tick();
      drive(1'b1, 5'd8, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      chk("t4_a1", 32'(bus_if.reg_w_addr_1), 32'd8);
      chk("t4_d1", bus_if.reg_w_data_1, 32'h55);
      chk("t4_en2", 32'(bus_if.reg_w_en_2), 32'd1);
      chk("t4_a2", 32'(bus_if.reg_w_addr_2), 32'd7);
      chk("t4_d2", bus_if.reg_w_data_2, 32'd9);
      idle();
      tick();

      // Fill the queue, hold a fifth request, then release and send an r0 write
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 5'(12 + i), 32'h300 + 32'(i));
         tick();
      end
      chk("t6_full", 32'(bus_if.ll_ready), 32'd0);
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 5'd16, 32'h316);
      tick();
      chk("t6_held", 32'(bus_if.ll_ready), 32'd0);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd16, 32'h316);
      tick();
      chk("t6_ready", 32'(bus_if.ll_ready), 32'd1);
      chk("t6_a1", 32'(bus_if.reg_w_addr_1), 32'd12);
      chk("t6_a2", 32'(bus_if.reg_w_addr_2), 32'd13);
      tick();
      chk("t6_b1", 32'(bus_if.reg_w_addr_1), 32'd14);
      chk("t6_b2", 32'(bus_if.reg_w_addr_2), 32'd15);
      chk("t6_r0_ready", 32'(bus_if.ll_ready), 32'd1);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
      tick();
      chk("t6_c1", 32'(bus_if.reg_w_addr_1), 32'd16);
      chk("t6_c1d", bus_if.reg_w_data_1, 32'h316);
      chk("t6_c2en", 32'(bus_if.reg_w_en_2), 32'd0);
      idle();
      tick();
      chk("t6_r0_en1", 32'(bus_if.reg_w_en_1), 32'd0);
      chk("t6_r0_en2", 32'(bus_if.reg_w_en_2), 32'd0);

      // Starvation: eight stuck cycles force a stall until the queue empties
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b1, 5'd20, 32'h400);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0);
         tick();
         if (i == 6) chk("t5_no_stall", 32'(bus_if.wb_stall), 32'd0);
      end
      chk("t5_stall", 32'(bus_if.wb_stall), 32'd1);
      idle();
      tick();
      chk("t5_drain_a1", 32'(bus_if.reg_w_addr_1), 32'd20);
      chk("t5_drain_stall", 32'(bus_if.wb_stall), 32'd1);
      tick();
      chk("t5_release", 32'(bus_if.wb_stall), 32'd0);

      repeat (600) begin
         rand_cycle(50);
         tick();
      end
      idle();
      repeat (12) tick();
      for (int r = 1; r < 32; r++) chk($sformatf("rf_r%0d", r), rf[r], mrf[r]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
